// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: result-source and load-size encodings
// plus the value every WB pipeline field takes on reset.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2,
    RES_IMM = 2'd3
  } res_src_e;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_e;

  localparam logic     FIELD_RST   = 1'b0;
  localparam res_src_e RES_SRC_RST = RES_ALU;
  localparam ld_size_e LD_SIZE_RST = LD_B;

endpackage

// File: rtl/wb_stage_pipe_load_align.sv
// Combinational load formatter: picks the addressed byte/half/word out of a raw
// memory word and sign- or zero-extends it to XLEN.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [2:0]      offset_i,
  input  ld_size_e        size_i,
  input  logic            uns_i,
  output logic [XLEN-1:0] res_o
);

  localparam int OW = (XLEN == 64) ? 3 : 2;

  logic [OW-1:0]   off;
  logic [XLEN-1:0] sh_b, sh_h, sh_w, sel, mask;
  logic            sbit;

  assign off  = offset_i[OW-1:0];
  assign sh_b = data_i >> {off, 3'b000};
  // Offset bits finer than the access size are dropped, so misaligned
  // addresses silently round down to the containing half/word.
  assign sh_h = data_i >> {off[OW-1:1], 4'b0000};
  assign sh_w = (XLEN == 64) ? (data_i >> {offset_i[2], 5'b00000}) : data_i;

  always_comb begin
    sel  = data_i;
    mask = '1;
    sbit = data_i[XLEN-1];
    case (size_i)
      LD_B: begin
        sel  = sh_b;
        mask = XLEN'(8'hFF);
        sbit = sh_b[7];
      end
      LD_H: begin
        sel  = sh_h;
        mask = XLEN'(16'hFFFF);
        sbit = sh_h[15];
      end
      LD_W: begin
        sel  = sh_w;
        mask = XLEN'(32'hFFFF_FFFF);
        sbit = sh_w[31];
      end
      default: begin
        sel  = data_i;
        mask = '1;
        sbit = data_i[XLEN-1];
      end
    endcase
    res_o = (sel & mask) | ((sbit && !uns_i) ? ~mask : '0);
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register and write-back result selection; drives the
// register-file write port, the forwarding value and the retire counter.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREG  = 32,
  parameter  int CNT_W = 64,
  localparam int RW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_M,
  input  logic             reg_we_M,
  input  logic [1:0]       res_src_M,
  input  logic [RW-1:0]    rd_M,
  input  logic [XLEN-1:0]  alu_out_M,
  input  logic [XLEN-1:0]  d_out_M,
  input  logic [XLEN-1:0]  pc_plus4_M,
  input  logic [XLEN-1:0]  imm_M,
  input  logic [1:0]       ld_size_M,
  input  logic             ld_uns_M,
  input  logic             stall_W,
  input  logic             flush_W,
  output logic             rf_we,
  output logic [RW-1:0]    rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             valid_W,
  output logic [CNT_W-1:0] instret
);

  logic             valid_q, valid_d;
  logic             reg_we_q, reg_we_d;
  res_src_e         res_src_q, res_src_d;
  logic [RW-1:0]    rd_q, rd_d;
  logic [XLEN-1:0]  alu_out_q, alu_out_d;
  logic [XLEN-1:0]  d_out_q, d_out_d;
  logic [XLEN-1:0]  pc4_q, pc4_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  ld_size_e         ld_size_q, ld_size_d;
  logic             ld_uns_q, ld_uns_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [XLEN-1:0]  ld_data;

  always_comb begin
    valid_d   = valid_q;
    reg_we_d  = reg_we_q;
    res_src_d = res_src_q;
    rd_d      = rd_q;
    alu_out_d = alu_out_q;
    d_out_d   = d_out_q;
    pc4_d     = pc4_q;
    imm_d     = imm_q;
    ld_size_d = ld_size_q;
    ld_uns_d  = ld_uns_q;
    // A flush only needs to kill the control bits; the payload is don't-care.
    if (flush_W) begin
      valid_d  = 1'b0;
      reg_we_d = 1'b0;
    end else if (!stall_W) begin
      valid_d   = valid_M;
      reg_we_d  = reg_we_M;
      res_src_d = res_src_e'(res_src_M);
      rd_d      = rd_M;
      alu_out_d = alu_out_M;
      d_out_d   = d_out_M;
      pc4_d     = pc_plus4_M;
      imm_d     = imm_M;
      ld_size_d = ld_size_e'(ld_size_M);
      ld_uns_d  = ld_uns_M;
    end
    instret_d = instret_q;
    if (valid_q && !stall_W) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= FIELD_RST;
      reg_we_q  <= FIELD_RST;
      res_src_q <= RES_SRC_RST;
      rd_q      <= '0;
      alu_out_q <= '0;
      d_out_q   <= '0;
      pc4_q     <= '0;
      imm_q     <= '0;
      ld_size_q <= LD_SIZE_RST;
      ld_uns_q  <= FIELD_RST;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      reg_we_q  <= reg_we_d;
      res_src_q <= res_src_d;
      rd_q      <= rd_d;
      alu_out_q <= alu_out_d;
      d_out_q   <= d_out_d;
      pc4_q     <= pc4_d;
      imm_q     <= imm_d;
      ld_size_q <= ld_size_d;
      ld_uns_q  <= ld_uns_d;
      instret_q <= instret_d;
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .data_i   (d_out_q),
    .offset_i (alu_out_q[2:0]),
    .size_i   (ld_size_q),
    .uns_i    (ld_uns_q),
    .res_o    (ld_data)
  );

  always_comb begin
    case (res_src_q)
      RES_MEM: rf_wdata = ld_data;
      RES_PC4: rf_wdata = pc4_q;
      RES_IMM: rf_wdata = imm_q;
      default: rf_wdata = alu_out_q;
    endcase
  end

  assign rf_we    = valid_q & reg_we_q & (rd_q != '0);
  assign rf_waddr = rd_q;
  assign valid_W  = valid_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: a 32-bit instance driven from a vector
// table plus stall/flush/reset sequences, and a 64-bit instance with a 4-bit counter.
module tb_wb_stage_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // 32-bit instance
  logic        a_valid = 0, a_we = 0, a_uns = 0, a_stall = 0, a_flush = 0;
  logic [1:0]  a_src = 0, a_size = 0;
  logic [4:0]  a_rd = 0;
  logic [31:0] a_alu = 0, a_dout = 0, a_pc4 = 0, a_imm = 0;
  logic        a_rf_we, a_valid_w;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic [63:0] a_instret;

  wb_stage_pipe #(.XLEN(32), .NREG(32), .CNT_W(64)) dut32 (
    .clk(clk), .rst_n(rst_n), .valid_M(a_valid), .reg_we_M(a_we), .res_src_M(a_src),
    .rd_M(a_rd), .alu_out_M(a_alu), .d_out_M(a_dout), .pc_plus4_M(a_pc4), .imm_M(a_imm),
    .ld_size_M(a_size), .ld_uns_M(a_uns), .stall_W(a_stall), .flush_W(a_flush),
    .rf_we(a_rf_we), .rf_waddr(a_waddr), .rf_wdata(a_wdata), .valid_W(a_valid_w),
    .instret(a_instret)
  );

  // 64-bit instance with a narrow counter for the wrap test
  logic        b_valid = 0, b_we = 0, b_uns = 0;
  logic [1:0]  b_src = 0, b_size = 0;
  logic [4:0]  b_rd = 0;
  logic [63:0] b_alu = 0, b_dout = 0, b_pc4 = 0, b_imm = 0;
  logic        b_rf_we, b_valid_w;
  logic [4:0]  b_waddr;
  logic [63:0] b_wdata;
  logic [3:0]  b_instret;

  wb_stage_pipe #(.XLEN(64), .NREG(32), .CNT_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .valid_M(b_valid), .reg_we_M(b_we), .res_src_M(b_src),
    .rd_M(b_rd), .alu_out_M(b_alu), .d_out_M(b_dout), .pc_plus4_M(b_pc4), .imm_M(b_imm),
    .ld_size_M(b_size), .ld_uns_M(b_uns), .stall_W(1'b0), .flush_W(1'b0),
    .rf_we(b_rf_we), .rf_waddr(b_waddr), .rf_wdata(b_wdata), .valid_W(b_valid_w),
    .instret(b_instret)
  );

  typedef struct {
    logic        valid;
    logic        we;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] dout;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [1:0]  size;
    logic        uns;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  // Bench-side view of the WB slot and retire counters
  logic        m_valid = 0;
  logic [63:0] m_cnt = 0;
  logic [3:0]  m64_cnt = 0;
  logic        m64_valid = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      passed++;
  endtask

  function automatic vec_t mk(input logic valid, input logic we, input logic [1:0] src,
                              input logic [4:0] rd, input logic [31:0] alu,
                              input logic [31:0] dout, input logic [31:0] pc4,
                              input logic [31:0] imm, input logic [1:0] size,
                              input logic uns, input logic exp_we,
                              input logic [31:0] exp_wdata);
    vec_t v;
    v.valid = valid; v.we = we; v.src = src; v.rd = rd; v.alu = alu; v.dout = dout;
    v.pc4 = pc4; v.imm = imm; v.size = size; v.uns = uns;
    v.exp_we = exp_we; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic drive32(input vec_t v);
    a_valid = v.valid; a_we = v.we; a_src = v.src; a_rd = v.rd; a_alu = v.alu;
    a_dout = v.dout; a_pc4 = v.pc4; a_imm = v.imm; a_size = v.size; a_uns = v.uns;
  endtask

  task automatic tick32();
    if (m_valid && !a_stall) m_cnt = m_cnt + 64'd1;
    if (a_flush) m_valid = 1'b0;
    else if (!a_stall) m_valid = a_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic tick64();
    if (m64_valid) m64_cnt = m64_cnt + 4'd1;
    m64_valid = b_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic ld64(input string nm, input logic [63:0] alu, input logic [63:0] dout,
                      input logic [1:0] size, input logic uns, input logic [63:0] exp);
    b_valid = 1; b_we = 1; b_rd = 5'd2; b_src = 2'd1; b_alu = alu; b_dout = dout;
    b_size = size; b_uns = uns;
    tick64();
    $display("x64 %s: wdata=%h instret=%0d", nm, b_wdata, b_instret);
    chk(nm, b_wdata, exp);
    chk({nm, "_cnt"}, 64'(b_instret), 64'(m64_cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks %0d", total);
    $fatal(1);
  end

  initial begin
    logic [31:0] hold_wdata;
    logic [63:0] hold_cnt;
    logic        wrap_seen;
    logic [3:0]  prev_cnt;

    // src: 0 ALU 1 MEM 2 PC4 3 IMM ; size: 0 B 1 H 2 W
    vecs[0]  = mk(1,1,2'd0,5'd5, 32'h1234_5678,32'h0,32'h0,32'h0,2'd0,0, 1,32'h1234_5678);
    vecs[1]  = mk(1,1,2'd1,5'd3, 32'h0000_0100,32'h80FF_7F81,32'h0,32'h0,2'd0,0, 1,32'hFFFF_FF81);
    vecs[2]  = mk(1,1,2'd1,5'd3, 32'h0000_0100,32'h80FF_7F81,32'h0,32'h0,2'd0,1, 1,32'h0000_0081);
    vecs[3]  = mk(1,1,2'd1,5'd4, 32'h0000_0101,32'h80FF_7F81,32'h0,32'h0,2'd0,0, 1,32'h0000_007F);
    vecs[4]  = mk(1,1,2'd1,5'd6, 32'h0000_0102,32'h80FF_7F81,32'h0,32'h0,2'd1,0, 1,32'hFFFF_80FF);
    vecs[5]  = mk(1,1,2'd1,5'd6, 32'h0000_0102,32'h80FF_7F81,32'h0,32'h0,2'd1,1, 1,32'h0000_80FF);
    vecs[6]  = mk(1,1,2'd1,5'd8, 32'h0000_0103,32'h80FF_7F81,32'h0,32'h0,2'd0,0, 1,32'hFFFF_FF80);
    vecs[7]  = mk(1,1,2'd1,5'd8, 32'h0000_0101,32'h80FF_7F81,32'h0,32'h0,2'd1,0, 1,32'h0000_7F81);
    vecs[8]  = mk(1,1,2'd1,5'd9, 32'h0000_0100,32'h80FF_7F81,32'h0,32'h0,2'd2,0, 1,32'h80FF_7F81);
    vecs[9]  = mk(1,1,2'd2,5'd0, 32'h0,32'h0,32'h0000_0044,32'h0,2'd0,0, 0,32'h0000_0044);
    vecs[10] = mk(1,1,2'd3,5'd31,32'h0,32'h0,32'h0,32'hABCD_E000,2'd0,0, 1,32'hABCD_E000);
    vecs[11] = mk(0,1,2'd0,5'd4, 32'hDEAD_BEEF,32'h0,32'h0,32'h0,2'd0,0, 0,32'hDEAD_BEEF);
    vecs[12] = mk(1,0,2'd0,5'd12,32'h0000_0CCC,32'h0,32'h0,32'h0,2'd0,0, 0,32'h0000_0CCC);
    vecs[13] = mk(1,1,2'd2,5'd1, 32'h0,32'h0,32'h0000_1000,32'h0,2'd0,0, 1,32'h0000_1000);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(a_valid_w), 64'd0);
    chk("rst_we", 64'(a_rf_we), 64'd0);
    chk("rst_waddr", 64'(a_waddr), 64'd0);
    chk("rst_wdata", 64'(a_wdata), 64'd0);
    chk("rst_instret", a_instret, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive32(vecs[i]);
      tick32();
      $display("vec %0d: we=%0b waddr=%0d wdata=%h instret=%0d",
               i, a_rf_we, a_waddr, a_wdata, a_instret);
      chk($sformatf("v%0d_we", i), 64'(a_rf_we), 64'(vecs[i].exp_we));
      chk($sformatf("v%0d_waddr", i), 64'(a_waddr), 64'(vecs[i].rd));
      chk($sformatf("v%0d_wdata", i), 64'(a_wdata), 64'(vecs[i].exp_wdata));
      chk($sformatf("v%0d_valid", i), 64'(a_valid_w), 64'(vecs[i].valid));
      chk($sformatf("v%0d_cnt", i), a_instret, m_cnt);
    end

    // Stall for three cycles with rd=7 in WB
    drive32(mk(1,1,2'd0,5'd7,32'h0000_0777,32'h0,32'h0,32'h0,2'd0,0,1,32'h777));
    tick32();
    hold_wdata = 32'h0000_0777;
    hold_cnt = m_cnt;
    a_stall = 1;
    drive32(mk(1,1,2'd0,5'd9,32'h0000_0999,32'h0,32'h0,32'h0,2'd0,0,1,32'h999));
    for (int c = 0; c < 3; c++) begin
      tick32();
      $display("stall %0d: we=%0b waddr=%0d wdata=%h instret=%0d",
               c, a_rf_we, a_waddr, a_wdata, a_instret);
      chk("stall_we", 64'(a_rf_we), 64'd1);
      chk("stall_waddr", 64'(a_waddr), 64'd7);
      chk("stall_wdata", 64'(a_wdata), 64'(hold_wdata));
      chk("stall_cnt", a_instret, hold_cnt);
    end
    a_stall = 0;
    tick32();
    $display("release: waddr=%0d wdata=%h instret=%0d", a_waddr, a_wdata, a_instret);
    chk("release_cnt", a_instret, hold_cnt + 64'd1);
    chk("release_waddr", 64'(a_waddr), 64'd9);

    // Stall and flush together: flush wins, nothing counted
    hold_cnt = a_instret;
    a_stall = 1; a_flush = 1;
    drive32(mk(1,1,2'd0,5'd10,32'h0000_0AAA,32'h0,32'h0,32'h0,2'd0,0,1,32'hAAA));
    tick32();
    $display("stall+flush: valid=%0b we=%0b instret=%0d", a_valid_w, a_rf_we, a_instret);
    chk("sf_valid", 64'(a_valid_w), 64'd0);
    chk("sf_we", 64'(a_rf_we), 64'd0);
    chk("sf_cnt", a_instret, hold_cnt);
    a_stall = 0; a_flush = 0;
    tick32();
    chk("sf_after_cnt", a_instret, m_cnt);

    // Flush alone kills the incoming instruction
    a_flush = 1;
    tick32();
    $display("flush: valid=%0b we=%0b instret=%0d", a_valid_w, a_rf_we, a_instret);
    chk("fl_valid", 64'(a_valid_w), 64'd0);
    chk("fl_cnt", a_instret, m_cnt);
    a_flush = 0;

    // Asynchronous reset while WB holds a valid writing instruction
    drive32(mk(1,1,2'd0,5'd11,32'h0000_0BBB,32'h0,32'h0,32'h0,2'd0,0,1,32'hBBB));
    tick32();
    chk("pre_rst_we", 64'(a_rf_we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("async rst: we=%0b wdata=%h instret=%0d", a_rf_we, a_wdata, a_instret);
    chk("arst_we", 64'(a_rf_we), 64'd0);
    chk("arst_wdata", 64'(a_wdata), 64'd0);
    chk("arst_valid", 64'(a_valid_w), 64'd0);
    chk("arst_cnt", a_instret, 64'd0);
    m_cnt = 0; m_valid = 0; a_valid = 0;
    m64_cnt = 0; m64_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // XLEN=64 load formatting
    ld64("lw_off4",  64'd4, 64'h8000_0001_0000_0002, 2'd2, 0, 64'hFFFF_FFFF_8000_0001);
    ld64("lwu_off4", 64'd4, 64'h8000_0001_0000_0002, 2'd2, 1, 64'h0000_0000_8000_0001);
    ld64("ld_off0",  64'd0, 64'h8000_0001_0000_0002, 2'd3, 0, 64'h8000_0001_0000_0002);
    ld64("lh_off6",  64'd6, 64'h8000_0001_0000_0002, 2'd1, 0, 64'hFFFF_FFFF_FFFF_8000);
    ld64("lb_off4",  64'd4, 64'h8000_0001_0000_0002, 2'd0, 0, 64'h0000_0000_0000_0001);

    // 4-bit retire counter wraps through all ones back to zero
    b_src = 2'd0; b_alu = 64'h55;
    wrap_seen = 0;
    for (int c = 0; c < 20; c++) begin
      prev_cnt = b_instret;
      tick64();
      if (prev_cnt == 4'hF && b_instret == 4'h0) wrap_seen = 1;
      $display("wrap %0d: instret=%0d", c, b_instret);
      chk("wrap_cnt", 64'(b_instret), 64'(m64_cnt));
    end
    chk("wrap_seen", 64'(wrap_seen), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
